// File: rtl/fp_divider_nr.sv
// Single-precision divider: a/b = (A'/D) * 2^(ea-eb-1), with 1/D refined by Newton-Raphson.
// One shared multiplier and one shared add/subtract unit, one operation per FSM state.

// Combinational single-precision multiply for normal operands.
// Low product bits are jammed into the LSB instead of being dropped.
module fp_mul (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_p
);
   logic [23:0] w_ma, w_mb;
   logic [47:0] w_prod;
   logic [46:0] w_norm;
   logic [9:0]  w_exp;

   // Multiply mantissas, normalise by at most one bit, add exponents.
   always_comb begin
      w_ma   = {1'b1, i_a[22:0]};
      w_mb   = {1'b1, i_b[22:0]};
      w_prod = 48'(w_ma) * 48'(w_mb);
      w_norm = w_prod[47] ? w_prod[46:0] : {w_prod[45:0], 1'b0};
      w_exp  = {2'b0, i_a[30:23]} + {2'b0, i_b[30:23]} - 10'd127 + {9'b0, w_prod[47]};
      o_p    = {i_a[31] ^ i_b[31], w_exp[7:0], w_norm[46:24] | {22'b0, |w_norm[23:0]}};
      if (i_a[30:23] == 8'd0 || i_b[30:23] == 8'd0) o_p = {i_a[31] ^ i_b[31], 31'b0};
   end
endmodule

// Combinational single-precision add/subtract (i_sub=1 gives a-b) for normal operands.
module fp_addsub (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_sub,
   output logic [31:0] o_s
);
   logic        w_sb, w_eff_sub;
   logic [31:0] w_x, w_y;
   logic [7:0]  w_sh;
   logic [26:0] w_mx, w_my;
   logic [27:0] w_sum, w_norm;
   logic [4:0]  w_lz;
   logic [9:0]  w_exp;

   // Order by magnitude, align, add or subtract, then renormalise on the leading one.
   always_comb begin
      w_sb = i_b[31] ^ i_sub;
      if (i_a[30:0] >= i_b[30:0]) begin
         w_x = i_a;
         w_y = {w_sb, i_b[30:0]};
      end else begin
         w_x = {w_sb, i_b[30:0]};
         w_y = i_a;
      end
      w_eff_sub = w_x[31] ^ w_y[31];
      w_sh      = w_x[30:23] - w_y[30:23];
      w_mx      = {1'b1, w_x[22:0], 3'b0};
      w_my      = (w_sh > 8'd26) ? 27'd0 : ({1'b1, w_y[22:0], 3'b0} >> w_sh);
      w_sum     = w_eff_sub ? ({1'b0, w_mx} - {1'b0, w_my}) : ({1'b0, w_mx} + {1'b0, w_my});
      w_lz      = 5'd0;
      for (int i = 0; i < 28; i++) if (w_sum[i]) w_lz = 5'(27 - i);
      w_norm    = w_sum << w_lz;
      w_exp     = {2'b0, w_x[30:23]} + 10'd1 - {5'b0, w_lz};
      o_s       = {w_x[31], w_exp[7:0], w_norm[26:4] | {22'b0, |w_norm[3:0]}};
      if (!w_norm[27])             o_s = 32'd0;
      if (w_y[30:23] == 8'd0)      o_s = w_x;
   end
endmodule

// state    | meaning
// IDLE     | waiting for start
// SEED_MUL | t = 0x3FF0F0F1 * D
// SEED_SUB | X = 0x4034B4B5 - t (linear seed of 1/D)
// IT_MUL   | t = D * X
// IT_SUB   | t = 2.0 - t
// IT_MUL2  | X = X * t, count one refinement
// FIN_MUL  | P = A' * X
// SCALE    | re-apply signs and exponents, detect over/underflow
// DONE     | result valid, done pulse
module fp_divider_nr #(
   parameter int ITERATIONS = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] operand_1,
   input  logic [31:0] operand_2,
   output logic        busy,
   output logic        done,
   output logic [31:0] solution,
   output logic        div_by_zero,
   output logic        invalid,
   output logic        overflow,
   output logic        underflow
);
   typedef enum logic [3:0] {
      IDLE, SEED_MUL, SEED_SUB, IT_MUL, IT_SUB, IT_MUL2, FIN_MUL, SCALE, DONE
   } state_t;

   localparam logic [2:0]  LP_ITER = 3'(ITERATIONS);
   localparam logic [31:0] LP_K1   = 32'h3FF0F0F1;
   localparam logic [31:0] LP_K2   = 32'h4034B4B5;
   localparam logic [31:0] LP_TWO  = 32'h40000000;

   state_t      r_state, w_next;
   logic [31:0] r_d, r_ap, r_x, r_t, r_sol;
   logic [7:0]  r_ea, r_eb;
   logic [2:0]  r_iter;
   logic        r_sign, r_dbz, r_inv, r_ovf, r_unf;

   logic [31:0] w_mul_a, w_mul_b, w_mul_p, w_add_a, w_add_b, w_add_s;
   logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_sgn;
   logic        w_special, w_spec_inv, w_spec_dbz;
   logic [31:0] w_spec_res, w_scale_res;
   logic signed [9:0] w_e;

   fp_mul    u_mul (.i_a(w_mul_a), .i_b(w_mul_b), .o_p(w_mul_p));
   fp_addsub u_add (.i_a(w_add_a), .i_b(w_add_b), .i_sub(1'b1), .o_s(w_add_s));

   // Classify operands at the start edge; denormals count as zero.
   always_comb begin
      w_a_zero   = operand_1[30:23] == 8'd0;
      w_b_zero   = operand_2[30:23] == 8'd0;
      w_a_inf    = operand_1[30:23] == 8'hFF && operand_1[22:0] == 23'd0;
      w_b_inf    = operand_2[30:23] == 8'hFF && operand_2[22:0] == 23'd0;
      w_a_nan    = operand_1[30:23] == 8'hFF && operand_1[22:0] != 23'd0;
      w_b_nan    = operand_2[30:23] == 8'hFF && operand_2[22:0] != 23'd0;
      w_sgn      = operand_1[31] ^ operand_2[31];
      w_special  = w_a_zero | w_b_zero | w_a_inf | w_b_inf | w_a_nan | w_b_nan;
      w_spec_inv = 1'b0;
      w_spec_dbz = 1'b0;
      if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
         w_spec_res = 32'h7FC00000;
         w_spec_inv = 1'b1;
      end else if (w_b_zero) begin
         w_spec_res = {w_sgn, 8'hFF, 23'd0};
         w_spec_dbz = 1'b1;
      end else if (w_a_zero || w_b_inf) begin
         w_spec_res = {w_sgn, 31'd0};
      end else begin
         w_spec_res = {w_sgn, 8'hFF, 23'd0};
      end
   end

   // Final exponent reconstruction from P held in r_t.
   always_comb begin
      w_e = signed'({2'b0, r_t[30:23]} + {2'b0, r_ea} - {2'b0, r_eb} - 10'd1);
      if (w_e >= 10'sd255)    w_scale_res = {r_sign, 8'hFF, 23'd0};
      else if (w_e <= 10'sd0) w_scale_res = {r_sign, 31'd0};
      else                    w_scale_res = {r_sign, w_e[7:0], r_t[22:0]};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next state and shared-unit operand selection.
   always_comb begin
      w_next  = r_state;
      w_mul_a = r_d;
      w_mul_b = r_x;
      w_add_a = LP_TWO;
      w_add_b = r_t;
      case (r_state)
         IDLE:     if (start) w_next = w_special ? DONE : SEED_MUL;
         SEED_MUL: begin w_mul_a = LP_K1; w_mul_b = r_d; w_next = SEED_SUB; end
         SEED_SUB: begin w_add_a = LP_K2; w_next = IT_MUL; end
         IT_MUL:   w_next = IT_SUB;
         IT_SUB:   w_next = IT_MUL2;
         IT_MUL2:  begin
            w_mul_a = r_x;
            w_mul_b = r_t;
            w_next  = (r_iter + 3'd1 == LP_ITER) ? FIN_MUL : IT_MUL;
         end
         FIN_MUL:  begin w_mul_a = r_ap; w_next = SCALE; end
         SCALE:    w_next = DONE;
         DONE:     w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // Datapath registers and held result/flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_d <= 32'd0; r_ap <= 32'd0; r_x <= 32'd0; r_t <= 32'd0; r_sol <= 32'd0;
         r_ea <= 8'd0; r_eb <= 8'd0; r_iter <= 3'd0; r_sign <= 1'b0;
         r_dbz <= 1'b0; r_inv <= 1'b0; r_ovf <= 1'b0; r_unf <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (start) begin
               r_d    <= {1'b0, 8'd126, operand_2[22:0]};
               r_ap   <= {1'b0, 8'd127, operand_1[22:0]};
               r_ea   <= operand_1[30:23];
               r_eb   <= operand_2[30:23];
               r_sign <= w_sgn;
               r_iter <= 3'd0;
               r_ovf  <= 1'b0;
               r_unf  <= 1'b0;
               r_inv  <= w_special & w_spec_inv;
               r_dbz  <= w_special & w_spec_dbz;
               if (w_special) r_sol <= w_spec_res;
            end
            SEED_MUL, IT_MUL, FIN_MUL: r_t <= w_mul_p;
            SEED_SUB: r_x <= w_add_s;
            IT_SUB:   r_t <= w_add_s;
            IT_MUL2:  begin r_x <= w_mul_p; r_iter <= r_iter + 3'd1; end
            SCALE:    begin
               r_sol <= w_scale_res;
               r_ovf <= (w_e >= 10'sd255);
               r_unf <= (w_e <= 10'sd0);
            end
            default: ;
         endcase
      end
   end

   assign busy        = (r_state != IDLE);
   assign done        = (r_state == DONE);
   assign solution    = r_sol;
   assign div_by_zero = r_dbz;
   assign invalid     = r_inv;
   assign overflow    = r_ovf;
   assign underflow   = r_unf;
endmodule

// File: tb/tb_fp_divider_nr.sv
// Directed bench for fp_divider_nr with ITERATIONS=3.
module tb_fp_divider_nr;
   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] operand_1, operand_2;
   logic        busy, done, div_by_zero, invalid, overflow, underflow;
   logic [31:0] solution;
   logic [3:0]  flags;
   int          n_err = 0, n_checks = 0, n_done = 0;

   int          lat;
   logic [31:0] sol;
   logic [3:0]  fl;
   logic        dn_nx, by_nx;

   fp_divider_nr #(.ITERATIONS(3)) dut (
      .clk(clk), .reset(reset), .start(start),
      .operand_1(operand_1), .operand_2(operand_2),
      .busy(busy), .done(done), .solution(solution),
      .div_by_zero(div_by_zero), .invalid(invalid),
      .overflow(overflow), .underflow(underflow)
   );

   assign flags = {div_by_zero, invalid, overflow, underflow};

   always #5 clk = ~clk;

   // Count done pulses as seen between clock edges.
   always @(negedge clk) if (done === 1'b1) n_done = n_done + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_ulp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      longint d;
      d = longint'({32'd0, obs}) - longint'({32'd0, exp});
      if (d < 0) d = -d;
      n_checks++;
      assert (!$isunknown(obs) && d <= 4) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h within 4 ulp", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; lat counts edges after the start edge.
   task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int l,
                          output logic [31:0] s, output logic [3:0] f,
                          output logic dnx, output logic bnx);
      start = 1'b1; operand_1 = a; operand_2 = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      l = 0;
      while (done !== 1'b1 && l < 100) begin
         @(negedge clk);
         l++;
      end
      s = solution; f = flags;
      @(negedge clk);
      dnx = done; bnx = busy;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; operand_1 = 32'd0; operand_2 = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_sol", solution, 32'd0);
      chk("reset_flags", {28'd0, flags}, 32'd0);

      run_div(32'h40C00000, 32'h40400000, lat, sol, fl, dn_nx, by_nx);
      chk("6/3_latency", lat, 13);
      chk_ulp("6/3_sol", sol, 32'h40000000);
      chk("6/3_flags", {28'd0, fl}, 32'd0);
      chk("6/3_done_once", {31'd0, dn_nx}, 32'd0);
      chk("6/3_idle_after", {31'd0, by_nx}, 32'd0);

      run_div(32'h3F800000, 32'h40400000, lat, sol, fl, dn_nx, by_nx);
      chk("1/3_latency", lat, 13);
      chk_ulp("1/3_sol", sol, 32'h3EAAAAAB);

      run_div(32'h41200000, 32'h40800000, lat, sol, fl, dn_nx, by_nx);
      chk_ulp("10/4_sol", sol, 32'h40200000);

      run_div(32'h3F800000, 32'h00000000, lat, sol, fl, dn_nx, by_nx);
      chk("1/0_latency", lat, 0);
      chk("1/0_sol", sol, 32'h7F800000);
      chk("1/0_flags", {28'd0, fl}, 32'h8);
      chk("1/0_done_once", {31'd0, dn_nx}, 32'd0);

      run_div(32'h00000000, 32'h00000000, lat, sol, fl, dn_nx, by_nx);
      chk("0/0_sol", sol, 32'h7FC00000);
      chk("0/0_flags", {28'd0, fl}, 32'h4);

      run_div(32'h7F800000, 32'hFF800000, lat, sol, fl, dn_nx, by_nx);
      chk("inf/inf_sol", sol, 32'h7FC00000);
      chk("inf/inf_flags", {28'd0, fl}, 32'h4);

      run_div(32'h80000000, 32'h40000000, lat, sol, fl, dn_nx, by_nx);
      chk("-0/2_sol", sol, 32'h80000000);
      chk("-0/2_flags", {28'd0, fl}, 32'h0);

      run_div(32'h7F800000, 32'hC0000000, lat, sol, fl, dn_nx, by_nx);
      chk("inf/-2_sol", sol, 32'hFF800000);

      run_div(32'h00000001, 32'h3F800000, lat, sol, fl, dn_nx, by_nx);
      chk("denorm_lat", lat, 0);
      chk("denorm_sol", sol, 32'h00000000);

      run_div(32'h7F000000, 32'h3E800000, lat, sol, fl, dn_nx, by_nx);
      chk("ovf_latency", lat, 13);
      chk("ovf_sol", sol, 32'h7F800000);
      chk("ovf_flags", {28'd0, fl}, 32'h2);

      run_div(32'h00800000, 32'h4B000000, lat, sol, fl, dn_nx, by_nx);
      chk("unf_sol", sol, 32'h00000000);
      chk("unf_flags", {28'd0, fl}, 32'h1);

      // Second start mid-divide must be ignored.
      n_done = 0;
      start = 1'b1; operand_1 = 32'h40C00000; operand_2 = 32'h40400000;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; operand_1 = 32'h3F800000; operand_2 = 32'h00000000;
      @(negedge clk);
      start = 1'b0;
      lat = 5;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      chk("restart_latency", lat, 13);
      chk_ulp("restart_sol", solution, 32'h40000000);
      chk("restart_flags", {28'd0, flags}, 32'h0);
      repeat (5) @(negedge clk);
      chk("restart_done_count", n_done, 1);

      // Reset during IT_MUL2 of the second refinement.
      start = 1'b1; operand_1 = 32'h40C00000; operand_2 = 32'h40400000;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      n_done = 0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_sol", solution, 32'd0);
      repeat (20) @(negedge clk);
      chk("abort_no_done", n_done, 0);
      run_div(32'h41200000, 32'h40800000, lat, sol, fl, dn_nx, by_nx);
      chk("after_abort_latency", lat, 13);
      chk_ulp("after_abort_sol", sol, 32'h40200000);

      // Reset wins over a simultaneous start.
      start = 1'b1; reset = 1'b1; operand_1 = 32'h3F800000; operand_2 = 32'h00000000;
      @(negedge clk);
      start = 1'b0; reset = 1'b0;
      chk("reset_vs_start_busy", {31'd0, busy}, 32'd0);
      chk("reset_vs_start_sol", solution, 32'd0);
      chk("reset_vs_start_flags", {28'd0, flags}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule

// File: doc/fp_divider_nr.md
FP_DIVIDER_NR -- requirements
Module: fp_divider_nr

Interface
REQ-001 SHALL have parameter ITERATIONS, default 3, meaning the number of Newton-Raphson reciprocal refinements (legal range 1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high.
REQ-004 SHALL have port start, input, 1, request to begin a divide; sampled only in IDLE.
REQ-005 SHALL have port operand_1, input, 32, IEEE-754 single dividend a.
REQ-006 SHALL have port operand_2, input, 32, IEEE-754 single divisor b.
REQ-007 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking solution and flags valid.
REQ-009 SHALL have port solution, output, 32, quotient a/b, held until the next accepted start.
REQ-010 SHALL have ports div_by_zero, invalid, overflow, underflow, each output, 1, exception flags, held with solution.

Function
REQ-011 SHALL latch operand_1/operand_2 on the edge where start=1 and state=IDLE; start in any other state SHALL be ignored.
REQ-012 SHALL time-share exactly one instance each of the team's combinational single-precision multiply and add/subtract units; one operation per state, result registered.
REQ-013 SHALL flush denormal operands to signed zero before classification.
REQ-014 SHALL form D = b mantissa with exponent 126 and sign 0 (D in [0.5,1)), and A' = a mantissa with exponent 127 and sign 0 (A' in [1,2)).
REQ-015 SHALL sequence IDLE -> SEED_MUL (t=0x3FF0F0F1*D) -> SEED_SUB (X=0x4034B4B5-t) -> {IT_MUL (t=D*X) -> IT_SUB (t=2.0-t) -> IT_MUL2 (X=X*t)} repeated ITERATIONS times -> FIN_MUL (P=A'*X) -> SCALE -> DONE -> IDLE.
REQ-016 SHALL use an iteration counter that increments in IT_MUL2 and leaves the loop when it equals ITERATIONS.
REQ-017 SCALE SHALL compute biased exponent e = P.exp + ea - eb - 1 in at least 10-bit signed arithmetic; sign = sa XOR sb; mantissa = P mantissa.
REQ-018 e >= 255 SHALL give signed infinity with overflow=1; e <= 0 SHALL give signed zero with underflow=1.
REQ-019 Normal-path latency: start sampled at edge 0, done high after edge 4+3*ITERATIONS (edge 13 for default), for exactly one cycle.
REQ-020 Special cases SHALL be decided at the start edge and go directly to DONE (done high after edge 0); in priority order: NaN operand, 0/0 or inf/inf -> 0x7FC00000, invalid=1; b zero -> signed infinity, div_by_zero=1; a zero or b infinite -> signed zero; a infinite -> signed infinity.
REQ-021 Normal-path results SHALL be within 4 ulp of the correctly rounded quotient.
REQ-022 Flags SHALL be cleared at each accepted start and set only by the operation that raises them.
REQ-023 done and busy SHALL never both be low while a result is pending; done SHALL coincide with state DONE (busy=1).

Reset
REQ-024 reset=1 at an edge SHALL force state IDLE, busy=0, done=0, solution=0x00000000, all flags 0, iteration counter 0, regardless of state.
REQ-025 reset asserted mid-operation SHALL abort it with no done pulse; reset SHALL dominate a simultaneous start.

Verification
REQ-026 0x40C00000 / 0x40400000 (6.0/3.0), ITERATIONS=3 -> solution 0x40000000 (+/-4 ulp), done exactly 13 edges after start, flags 0.
REQ-027 0x3F800000 / 0x00000000 -> solution 0x7F800000, div_by_zero=1, done after 1 edge.
REQ-028 0x00000000 / 0x00000000 and 0x7F800000 / 0xFF800000 -> solution 0x7FC00000, invalid=1.
REQ-029 0x7F000000 / 0x3E800000 -> solution 0x7F800000, overflow=1; 0x00800000 / 0x4B000000 -> solution 0x00000000, underflow=1.
REQ-030 Second start with different operands 5 cycles into a divide -> ignored; only first quotient delivered, single done pulse.
REQ-031 reset pulsed during IT_MUL2 of the second iteration -> next cycle busy=0, solution=0, no done; a following start divides normally.
